// File: rtl/multi_input_unit.sv
// Button-driven binary word entry (shift 0 / shift 1 / backspace / commit)
// feeding a first-word-fall-through FIFO drained over a valid/ready handshake.
module multi_input_unit #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(WIDTH + 1),
   localparam int FW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             btn_zero,
   input  logic             btn_one,
   input  logic             btn_del,
   input  logic             btn_next,
   output logic [WIDTH-1:0] cur_value,
   output logic [CW-1:0]    bit_cnt,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FW-1:0]    fifo_count,
   output logic             full,
   output logic             overflow
);

   localparam int PW = $clog2(DEPTH);

   logic zero_d, one_d, del_d, next_d;
   logic zero_r, one_r, del_r, next_r;

   logic [WIDTH-1:0] cur_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic             push, pop, ovf_nxt;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_d <= 1'b0;
         one_d  <= 1'b0;
         del_d  <= 1'b0;
         next_d <= 1'b0;
      end else begin
         zero_d <= btn_zero;
         one_d  <= btn_one;
         del_d  <= btn_del;
         next_d <= btn_next;
      end
   end

   // Edge registers keep running while disabled; only the events are masked.
   assign zero_r = enable & btn_zero & ~zero_d;
   assign one_r  = enable & btn_one  & ~one_d;
   assign del_r  = enable & btn_del  & ~del_d;
   assign next_r = enable & btn_next & ~next_d;

   assign full      = (fifo_count == FW'(DEPTH));
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid & out_ready;
   assign out_data  = mem[rd_ptr];

   // NOTE: every variable gets a default before any branch, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      cur_nxt = cur_value;
      cnt_nxt = bit_cnt;
      push    = 1'b0;
      ovf_nxt = 1'b0;
      if (!enable) begin
         cur_nxt = '0;
         cnt_nxt = '0;
      end else if (del_r) begin
         if (bit_cnt != '0) begin
            cur_nxt = cur_value >> 1;
            cnt_nxt = bit_cnt - CW'(1);
         end
      end else begin
         if ((zero_r ^ one_r) && (bit_cnt != CW'(WIDTH))) begin
            cur_nxt = {cur_value[WIDTH-2:0], one_r};
            cnt_nxt = bit_cnt + CW'(1);
         end
         // A bit can only be accepted below WIDTH, so it never collides with a commit.
         if (next_r && (bit_cnt == CW'(WIDTH))) begin
            if (!full || pop) begin
               push    = 1'b1;
               cur_nxt = '0;
               cnt_nxt = '0;
            end else begin
               ovf_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_value  <= '0;
         bit_cnt    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         cur_value <= cur_nxt;
         bit_cnt   <= cnt_nxt;
         overflow  <= ovf_nxt;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + FW'(1);
            2'b01:   fifo_count <= fifo_count - FW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // NOTE: the storage array is not reset; its contents are only observed
   // through out_data while out_valid qualifies them.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cur_value;
   end

endmodule
